// File: rtl/extmem_arbiter_pkg.sv
// Shared constants for the external-memory arbiter: state and grant encodings
// plus default bus widths and arbitration limits.
package extmem_arbiter_pkg;

    localparam int AW_DEF      = 13;
    localparam int DW_DEF      = 32;
    localparam int STARVE_DEF  = 4;
    localparam int TIMEOUT_DEF = 15;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_BUSY = 2'b01;
    localparam logic [1:0] ST_RESP = 2'b10;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } gnt_e;

endpackage

// File: rtl/extmem_arbiter_if.sv
// Requester and memory-side signals of the arbiter; the bidirectional memory
// data bus stays a plain inout on the top so tristate resolution is explicit.
interface extmem_arbiter_if
    import extmem_arbiter_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
);
    logic            ireq;
    logic [AW-1:0]   iadr;
    logic            iack;
    logic [DW-1:0]   irdata;

    logic            dreq;
    logic            drwb;
    logic [AW-1:0]   dadr;
    logic [DW-1:0]   dwdata;
    logic [DW/8-1:0] dbyteen;
    logic            dack;
    logic [DW-1:0]   drdata;

    logic            err;

    logic [AW-1:0]   memadr;
    logic [DW/8-1:0] membyteen;
    logic            memrwb;
    logic            memen;
    logic            memdone;

    // Arbiter view.
    modport slave (
        input  ireq, iadr, dreq, drwb, dadr, dwdata, dbyteen, memdone,
        output iack, irdata, dack, drdata, err,
               memadr, membyteen, memrwb, memen
    );

    // Requesters and memory view.
    modport master (
        output ireq, iadr, dreq, drwb, dadr, dwdata, dbyteen, memdone,
        input  iack, irdata, dack, drdata, err,
               memadr, membyteen, memrwb, memen
    );
endinterface

// File: rtl/extmem_arb_prio.sv
// Data-over-instruction priority with a starvation counter that forces an
// instruction grant after STARVE consecutive data grants taken while ireq waited.
module extmem_arb_prio
    import extmem_arbiter_pkg::*;
#(
    parameter int STARVE = STARVE_DEF
) (
    input  logic ph1,
    input  logic reset,
    input  logic ireq,
    input  logic dreq,
    input  logic sample,
    output logic gnt_d
);
    localparam int CW = (STARVE > 0) ? $clog2(STARVE + 1) : 1;

    logic [CW-1:0] r_cnt;
    logic          w_starved;

    assign w_starved = ireq && (r_cnt == CW'(STARVE));
    assign gnt_d     = dreq && !w_starved;

    // The count can never pass STARVE: at STARVE the instruction side wins and clears it.
    always_ff @(posedge ph1) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (sample) begin
            if (!ireq)
                r_cnt <= '0;
            else if (gnt_d)
                r_cnt <= r_cnt + CW'(1);
            else
                r_cnt <= '0;
        end
    end

endmodule

// File: rtl/extmem_arbiter.sv
// Shares one external memory port between instruction fetch and data requesters:
// IDLE latches a winner, BUSY drives the bus until done or timeout, RESP acks.
module extmem_arbiter
    import extmem_arbiter_pkg::*;
#(
    parameter int AW      = AW_DEF,
    parameter int DW      = DW_DEF,
    parameter int STARVE  = STARVE_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic          ph1,
    input  logic          reset,
    extmem_arbiter_if.slave bus,
    inout  wire [DW-1:0]  memdata
);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [1:0]      r_state;
    gnt_e            r_gnt;
    logic            r_rwb;
    logic [AW-1:0]   r_adr;
    logic [DW-1:0]   r_wdata;
    logic [DW/8-1:0] r_be;
    logic [TW-1:0]   r_tcnt;
    logic            r_err;
    logic [DW-1:0]   r_irdata;
    logic [DW-1:0]   r_drdata;

    logic w_idle;
    logic w_busy;
    logic w_resp;
    logic w_write;
    logic w_gnt_d;

    assign w_idle  = (r_state == ST_IDLE);
    assign w_busy  = (r_state == ST_BUSY);
    assign w_resp  = (r_state == ST_RESP);
    assign w_write = w_busy && !r_rwb;

    extmem_arb_prio #(
        .STARVE (STARVE)
    ) u_prio (
        .ph1    (ph1),
        .reset  (reset),
        .ireq   (bus.ireq),
        .dreq   (bus.dreq),
        .sample (w_idle),
        .gnt_d  (w_gnt_d)
    );

    // Bus controls decode straight from state so a reset edge releases them at once.
    assign memdata       = w_write ? r_wdata : {DW{1'bz}};
    assign bus.memen     = w_busy;
    assign bus.memrwb    = !w_write;
    assign bus.memadr    = w_busy ? r_adr : '0;
    assign bus.membyteen = w_write ? r_be : '0;

    assign bus.iack   = w_resp && (r_gnt == GNT_I);
    assign bus.dack   = w_resp && (r_gnt == GNT_D);
    assign bus.err    = w_resp && r_err;
    assign bus.irdata = r_irdata;
    assign bus.drdata = r_drdata;

    always_ff @(posedge ph1) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_gnt    <= GNT_I;
            r_rwb    <= 1'b1;
            r_adr    <= '0;
            r_wdata  <= '0;
            r_be     <= '0;
            r_tcnt   <= '0;
            r_err    <= 1'b0;
            r_irdata <= '0;
            r_drdata <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.ireq || bus.dreq) begin
                        r_state <= ST_BUSY;
                        r_tcnt  <= '0;
                        r_err   <= 1'b0;
                        if (w_gnt_d) begin
                            r_gnt   <= GNT_D;
                            r_adr   <= bus.dadr;
                            r_rwb   <= bus.drwb;
                            r_wdata <= bus.dwdata;
                            r_be    <= bus.dbyteen;
                        end else begin
                            r_gnt   <= GNT_I;
                            r_adr   <= bus.iadr;
                            r_rwb   <= 1'b1;
                            r_wdata <= '0;
                            r_be    <= '0;
                        end
                    end
                end
                ST_BUSY: begin
                    if (bus.memdone) begin
                        r_state <= ST_RESP;
                        if (r_rwb) begin
                            if (r_gnt == GNT_D)
                                r_drdata <= memdata;
                            else
                                r_irdata <= memdata;
                        end
                    end else if (r_tcnt == TW'(TIMEOUT - 1)) begin
                        r_state <= ST_RESP;
                        r_err   <= 1'b1;
                    end else begin
                        r_tcnt <= r_tcnt + TW'(1);
                    end
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_extmem_arbiter.sv
// Directed bench for extmem_arbiter with a small byte-enabled memory model whose
// done latency is programmable; each access prints one line.
module tb_extmem_arbiter;
    import extmem_arbiter_pkg::*;

    logic ph1   = 1'b0;
    logic reset = 1'b1;
    always #5 ph1 = ~ph1;

    extmem_arbiter_if #(.AW(13), .DW(32)) bus ();
    wire [31:0] memdata;

    extmem_arbiter #(
        .AW      (13),
        .DW      (32),
        .STARVE  (4),
        .TIMEOUT (15)
    ) dut (
        .ph1     (ph1),
        .reset   (reset),
        .bus     (bus),
        .memdata (memdata)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Memory model: word i initialised to C0DE_00ii, done after mem_wait BUSY cycles.
    logic [31:0] mem [0:63];
    int          mem_cnt;
    int          mem_wait;

    always @(posedge ph1) begin
        if (reset) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'hC0DE0000 | 32'(i);
            mem_cnt <= 0;
        end else begin
            mem_cnt <= bus.memen ? mem_cnt + 1 : 0;
            if (bus.memen && !bus.memrwb && bus.memdone)
                for (int b = 0; b < 4; b++)
                    if (bus.membyteen[b]) mem[bus.memadr[5:0]][b*8 +: 8] <= memdata[b*8 +: 8];
        end
    end

    assign bus.memdone = bus.memen && (mem_cnt == mem_wait);
    assign memdata     = (bus.memen && bus.memrwb) ? mem[bus.memadr[5:0]] : 32'hz;

    task automatic wait_ack(input int budget, output int busy, output bit gi, output bit gd, output bit e);
        busy = 0; gi = 0; gd = 0; e = 0;
        for (int k = 0; k < budget; k++) begin
            @(negedge ph1);
            if (bus.memen) busy++;
            if (bus.iack || bus.dack) begin
                gi = bus.iack; gd = bus.dack; e = bus.err;
                break;
            end
        end
        chk("ack_seen", 64'(gi | gd), 64'd1);
        $display("txn: iack=%0b dack=%0b err=%0b busy=%0d irdata=%h drdata=%h",
                 gi, gd, e, busy, bus.irdata, bus.drdata);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  busy;
        bit  gi, gd, e;
        int  nd, ni;
        logic [31:0] seen_i;
        logic [5:0]  exp_d;

        bus.ireq = 0; bus.iadr = '0;
        bus.dreq = 0; bus.drwb = 1; bus.dadr = '0; bus.dwdata = '0; bus.dbyteen = '0;
        mem_wait = 0;
        repeat (3) @(negedge ph1);

        // Reset state
        chk("rst_memen",  bus.memen, 0);
        chk("rst_memrwb", bus.memrwb, 1);
        chk("rst_iack",   bus.iack, 0);
        chk("rst_dack",   bus.dack, 0);
        chk("rst_err",    bus.err, 0);
        chk("rst_memadr", bus.memadr, 0);
        chk("rst_be",     bus.membyteen, 0);
        chk("rst_irdata", bus.irdata, 0);
        chk("rst_drdata", bus.drdata, 0);
        reset = 0;

        // Instruction read of word 4, done in first BUSY cycle
        bus.iadr = 13'h0004; bus.ireq = 1;
        @(negedge ph1);
        chk("i_busy_memen",  bus.memen, 1);
        chk("i_busy_memadr", bus.memadr, 13'h0004);
        chk("i_busy_memrwb", bus.memrwb, 1);
        chk("i_busy_iack",   bus.iack, 0);
        @(negedge ph1);
        chk("i_resp_iack",   bus.iack, 1);
        chk("i_resp_irdata", bus.irdata, 32'hC0DE0004);
        chk("i_resp_memen",  bus.memen, 0);
        chk("i_resp_memadr", bus.memadr, 0);
        $display("txn: iread adr=0004 irdata=%h", bus.irdata);
        bus.ireq = 0;
        @(negedge ph1);
        chk("i_after_iack", bus.iack, 0);

        // Partial data write then read-back
        bus.dadr = 13'h0010; bus.dwdata = 32'hDEADBEEF; bus.dbyteen = 4'b0011; bus.drwb = 0; bus.dreq = 1;
        @(negedge ph1);
        chk("w_busy_memrwb",  bus.memrwb, 0);
        chk("w_busy_be",      bus.membyteen, 4'b0011);
        chk("w_busy_memdata", memdata, 32'hDEADBEEF);
        chk("w_busy_memen",   bus.memen, 1);
        @(negedge ph1);
        chk("w_resp_dack",   bus.dack, 1);
        chk("w_resp_err",    bus.err, 0);
        chk("w_resp_memrwb", bus.memrwb, 1);
        $display("txn: dwrite adr=0010 data=DEADBEEF be=3");
        bus.dreq = 0;
        @(negedge ph1);
        bus.drwb = 1; bus.dreq = 1;
        wait_ack(40, busy, gi, gd, e);
        chk("rb_busy",   busy, 1);
        chk("rb_dack",   gd, 1);
        chk("rb_drdata", bus.drdata, 32'hC0DEBEEF);
        bus.dreq = 0;
        @(negedge ph1);

        // Starvation: both held, order D D D D I D
        exp_d = 6'b101111;
        bus.iadr = 13'h0001; bus.dadr = 13'h0002; bus.drwb = 1;
        bus.ireq = 1; bus.dreq = 1;
        for (int a = 0; a < 6; a++) begin
            wait_ack(40, busy, gi, gd, e);
            chk($sformatf("starve_gd%0d", a), gd, exp_d[a]);
            chk($sformatf("starve_gi%0d", a), gi, !exp_d[a]);
            if (gd) chk($sformatf("starve_drd%0d", a), bus.drdata, 32'hC0DE0002);
            else    chk($sformatf("starve_ird%0d", a), bus.irdata, 32'hC0DE0001);
        end
        bus.ireq = 0; bus.dreq = 0;
        @(negedge ph1);

        // Timeout: memory never completes
        mem_wait = 100;
        bus.dadr = 13'h0003; bus.drwb = 1; bus.dreq = 1;
        wait_ack(40, busy, gi, gd, e);
        chk("to_busy", busy, 15);
        chk("to_dack", gd, 1);
        chk("to_err",  e, 1);
        bus.dreq = 0;
        @(negedge ph1);
        chk("to_idle_memen", bus.memen, 0);
        chk("to_idle_err",   bus.err, 0);
        chk("to_idle_dack",  bus.dack, 0);

        // Reset in the middle of a write
        bus.dadr = 13'h0005; bus.dwdata = 32'hFFFFFFFF; bus.dbyteen = 4'hF; bus.drwb = 0; bus.dreq = 1;
        @(negedge ph1);
        chk("rw_busy_memrwb", bus.memrwb, 0);
        chk("rw_busy_memen",  bus.memen, 1);
        reset = 1;
        @(negedge ph1);
        chk("rw_rst_memrwb", bus.memrwb, 1);
        chk("rw_rst_memen",  bus.memen, 0);
        chk("rw_rst_dack",   bus.dack, 0);
        bus.dreq = 0; reset = 0;
        nd = 0;
        repeat (4) begin
            @(negedge ph1);
            if (bus.dack) nd++;
        end
        chk("rw_no_dack", nd, 0);
        $display("txn: aborted write adr=0005");
        mem_wait = 0;
        bus.drwb = 1; bus.dreq = 1;
        wait_ack(40, busy, gi, gd, e);
        chk("rw_rb_drdata", bus.drdata, 32'hC0DE0005);
        bus.dreq = 0;
        @(negedge ph1);

        // dreq dropped during BUSY while ireq waits
        mem_wait = 2;
        bus.dadr = 13'h0006; bus.drwb = 1; bus.iadr = 13'h0007;
        bus.dreq = 1; bus.ireq = 1;
        @(negedge ph1);
        chk("drop_busy_memadr", bus.memadr, 13'h0006);
        bus.dreq = 0;
        nd = 0; ni = 0; seen_i = '0;
        for (int k = 0; k < 20; k++) begin
            @(negedge ph1);
            if (bus.dack) begin
                nd++;
                chk("drop_drdata", bus.drdata, 32'hC0DE0006);
                chk("drop_first_is_d", ni, 0);
                $display("txn: dread adr=0006 drdata=%h", bus.drdata);
            end
            if (bus.iack) begin
                ni++;
                seen_i = bus.irdata;
                bus.ireq = 0;
                $display("txn: iread adr=0007 irdata=%h", bus.irdata);
            end
        end
        chk("drop_dack_cnt", nd, 1);
        chk("drop_iack_cnt", ni, 1);
        chk("drop_irdata",   seen_i, 32'hC0DE0007);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
